imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-path stage directly upstream of the CPU/instruction-memory pair.
- Receives a framed byte stream through a valid/ready interface and assembles big-endian 32-bit words.
- Writes those words sequentially into instruction memory and holds the CPU in reset until the image is complete.
- Replaces the static hex preload, so the FPGA can be reprogrammed without resynthesis.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width (memory depth is 2^ADDR_WIDTH words).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between accepted bytes inside a frame.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- rx_valid  input  1  byte source has valid data.
- rx_data  input  8  byte from source.
- rx_ready  output  1  loader can accept a byte; a transfer occurs when rx_valid && rx_ready at a rising edge.
- imem_we  output  1  instruction-memory write enable.
- imem_addr  output  ADDR_WIDTH  word address of the write.
- imem_wd  output  32  write data.
- cpu_reset  output  1  drives the CPU reset.
- busy  output  1  load in progress.
- done  output  1  last load completed successfully.
- error  output  1  last load aborted.
- words_loaded  output  ADDR_WIDTH+1  count of words written in the current or last load.

Behaviour:
- Interface: one clock, named clock. reset is asynchronous and active-high. All state registers clear on reset assertion, independent of clock.
- Reset values:
  - State is IDLE.
  - rx_ready, imem_we, busy, done, error = 0.
  - imem_addr, imem_wd, words_loaded = 0.
  - cpu_reset = 1 while reset is high: cpu_reset = reset OR (state not in {IDLE, DONE}).
- Outputs are Moore decodes of the state register. busy=1 in SYNC, LEN_HI, LEN_LO, DATA and WRITE. done=1 only in DONE. error=1 only in ERROR.
- States and transitions:
  - IDLE: rx_ready=0. start goes to SYNC and clears words_loaded, the word index and the byte index.
  - SYNC: rx_ready=1. An accepted byte equal to SYNC_BYTE goes to LEN_HI. Any other accepted byte is discarded and the state stays SYNC. No timeout in this state.
  - LEN_HI: rx_ready=1. The accepted byte becomes count[15:8]; go to LEN_LO.
  - LEN_LO: rx_ready=1. The accepted byte becomes count[7:0]. Then:
    - count == 0 goes to DONE.
    - count > 2^ADDR_WIDTH goes to ERROR.
    - Otherwise go to DATA.
  - DATA: rx_ready=1. Bytes assemble big-endian: the first byte goes to [31:24] and the fourth to [7:0]. Acceptance of the fourth byte goes to WRITE.
  - WRITE: rx_ready=0, imem_we=1 for exactly one cycle, imem_addr = word index, imem_wd = assembled word. On leaving WRITE, the word index and words_loaded increment. If the new index equals count, go to DONE; otherwise return to DATA with byte index 0.
  - DONE: rx_ready=0, cpu_reset=0. start goes to SYNC.
  - ERROR: rx_ready=0, cpu_reset=1 (held until a successful reload). start goes to SYNC.
- Latency: the fourth data byte is accepted at edge N. imem_we is high in the cycle after edge N, and the write is captured at edge N+1. DATA resumes one cycle later, so throughput is at most 4 bytes per 5 cycles.
- Timeout:
  - The counter runs in LEN_HI, LEN_LO and DATA, and clears on every accepted byte and on state entry.
  - Reaching TIMEOUT_CYCLES goes to ERROR. A byte accepted in the same cycle wins over the timeout.
- Edge cases:
  - start while busy is ignored.
  - rx_valid while rx_ready=0 is not consumed; the source must hold the byte.
  - count == 2^ADDR_WIDTH is legal: the final imem_addr is all ones, and words_loaded reaches 2^ADDR_WIDTH without wrapping.
  - Reset asserted mid-load returns to IDLE immediately. Memory contents written so far remain, and cpu_reset stays high until reset is released.

Test Plan:
- Reset, then start, then stream A5 00 02 DE AD BE EF 01 23 45 67 -> two imem_we pulses: addr 0 data DEADBEEF, addr 1 data 01234567. Then done=1, cpu_reset=0, words_loaded=2.
- Stream 11 22 A5 00 01 00 00 00 2A after start -> leading 11 and 22 discarded; one write at addr 0 data 0000002A; DONE.
- Length 04 01 (1025) with ADDR_WIDTH=10 -> ERROR after the LEN_LO byte, error=1, cpu_reset=1, no imem_we.
- TIMEOUT_CYCLES=16, stall rx_valid after 2 data bytes -> ERROR exactly 16 cycles after the last accepted byte. A subsequent start plus a valid frame ends in DONE.
- Hold rx_valid=1 continuously with 4 bytes of data -> rx_ready=0 during the WRITE cycle, the fifth byte is not lost, and the byte ordering across the stall is correct.
- Assert reset in the middle of the third word of a 4-word load -> state IDLE immediately, busy=0, cpu_reset=1 during reset and 0 one cycle after release. The earlier two writes are unaffected.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: assembles a framed big-endian byte stream into 32-bit words,
// writes them into instruction memory and holds the CPU in reset until done.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wd,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [15:0]           count;
    logic [31:0]           word;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            byte_idx;
    logic [TW-1:0]         tcnt;

    logic        accept;
    logic        start_ok;
    logic        timed;
    logic        timeout_hit;
    logic        last_word;
    logic [15:0] len_full;

    // Moore decodes of the state register
    assign rx_ready  = (state == S_SYNC) || (state == S_LEN_HI) ||
                       (state == S_LEN_LO) || (state == S_DATA);
    assign imem_we   = (state == S_WRITE);
    assign busy      = rx_ready || (state == S_WRITE);
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERROR);
    assign cpu_reset = reset || !((state == S_IDLE) || (state == S_DONE));
    assign imem_addr = word_idx;
    assign imem_wd   = word;

    assign accept      = rx_valid && rx_ready;
    assign start_ok    = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign timed       = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
    assign timeout_hit = timed && !accept && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign len_full    = {count[15:8], rx_data};
    // words_loaded is one bit wider than the address, so a full-depth image compares cleanly
    assign last_word   = ((32'(words_loaded) + 32'd1) == 32'(count));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_ok) state_next = S_SYNC;
            end
            S_SYNC: begin
                if (accept && (rx_data == SYNC_BYTE)) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept)           state_next = S_LEN_LO;
                else if (timeout_hit) state_next = S_ERROR;
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (len_full == 16'd0)                state_next = S_DONE;
                    else if (32'(len_full) > MAX_WORDS)   state_next = S_ERROR;
                    else                                  state_next = S_DATA;
                end else if (timeout_hit) begin
                    state_next = S_ERROR;
                end
            end
            S_DATA: begin
                if (accept && (byte_idx == 2'd3)) state_next = S_WRITE;
                else if (timeout_hit)             state_next = S_ERROR;
            end
            S_WRITE: begin
                state_next = last_word ? S_DONE : S_DATA;
            end
            S_DONE: begin
                if (start_ok) state_next = S_SYNC;
            end
            S_ERROR: begin
                if (start_ok) state_next = S_SYNC;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: length capture, word assembly, write indices and idle timer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count        <= '0;
            word         <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            words_loaded <= '0;
            tcnt         <= '0;
        end else begin
            if (accept || !timed || (state_next != state)) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end

            if (start_ok) begin
                word_idx     <= '0;
                byte_idx     <= '0;
                words_loaded <= '0;
            end

            if (accept) begin
                case (state)
                    S_LEN_HI: count[15:8] <= rx_data;
                    S_LEN_LO: count[7:0]  <= rx_data;
                    S_DATA: begin
                        word     <= {word[23:0], rx_data};
                        byte_idx <= byte_idx + 2'd1;
                    end
                    default: ;
                endcase
            end

            if (state == S_WRITE) begin
                word_idx     <= word_idx + ADDR_WIDTH'(1);
                words_loaded <= words_loaded + (ADDR_WIDTH + 1)'(1);
            end
        end
    end

endmodule
